// File: rtl/lcd_pixel_writer_if.sv
// Request side (pixel / cursor-home) and ILI9341 8080-style bus of lcd_pixel_writer.
// The writer block uses the slave modport; the pixel source uses master.
interface lcd_pixel_writer_if;
  logic [15:0] pix_data;
  logic        pix_clk;
  logic        reset_cursor;
  logic        busy;
  logic        overrun;
  logic        nreset;
  logic        cmd_data;
  logic        write_edge;
  logic [7:0]  dout;

  modport master (
    output pix_data, pix_clk, reset_cursor,
    input  busy, overrun, nreset, cmd_data, write_edge, dout
  );

  modport slave (
    input  pix_data, pix_clk, reset_cursor,
    output busy, overrun, nreset, cmd_data, write_edge, dout
  );
endinterface

// File: rtl/lcd_pixel_writer.sv
// ILI9341 8-bit parallel writer: panel power-up, init ROM, cursor-home window
// setup and RGB565 pixel streaming, each bus byte being a 2-cycle strobe.
module lcd_pixel_writer #(
  parameter int unsigned RESET_HOLD = 16000,
  parameter int unsigned RESET_WAIT = 1920000,
  parameter logic [7:0]  MADCTL     = 8'h28
) (
  input logic               clk_i,
  input logic               rst_i,
  lcd_pixel_writer_if.slave bus
);

  localparam int unsigned CNT_MAX = (RESET_HOLD > RESET_WAIT) ? RESET_HOLD : RESET_WAIT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RESET_WAIT - 1);
  localparam logic [4:0] CURSOR_IDX = 5'd7;
  localparam logic [4:0] LAST_IDX   = 5'd17;

  typedef enum logic [2:0] {
    HW_HOLD,
    HW_WAIT,
    SEQ,
    DELAY,
    IDLE,
    PIXEL
  } state_t;

  // Init ROM entry as {dc, byte}; entries 7..17 form the cursor-home sequence.
  function automatic logic [8:0] rom(input logic [4:0] idx);
    case (idx)
      5'd0:    return {1'b0, 8'h01};
      5'd1:    return {1'b0, 8'h11};
      5'd2:    return {1'b0, 8'h3A};
      5'd3:    return {1'b1, 8'h55};
      5'd4:    return {1'b0, 8'h36};
      5'd5:    return {1'b1, MADCTL};
      5'd6:    return {1'b0, 8'h29};
      5'd7:    return {1'b0, 8'h2A};
      5'd8:    return {1'b1, 8'h00};
      5'd9:    return {1'b1, 8'h00};
      5'd10:   return {1'b1, 8'h01};
      5'd11:   return {1'b1, 8'h3F};
      5'd12:   return {1'b0, 8'h2B};
      5'd13:   return {1'b1, 8'h00};
      5'd14:   return {1'b1, 8'h00};
      5'd15:   return {1'b1, 8'h00};
      5'd16:   return {1'b1, 8'hEF};
      5'd17:   return {1'b0, 8'h2C};
      default: return {1'b0, 8'h00};
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic [7:0]       pix_lo_byte_q, pix_lo_byte_d;
  logic             pix_lo_q, pix_lo_d;
  logic             nreset_q, nreset_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             we_q, we_d;
  logic             dc_q, dc_d;
  logic [7:0]       dout_q, dout_d;

  logic [8:0] first_entry;
  logic [8:0] cursor_entry;
  logic [8:0] next_entry;
  logic       has_delay;

  always_comb begin
    first_entry  = rom(5'd0);
    cursor_entry = rom(CURSOR_IDX);
    next_entry   = rom(idx_q + 5'd1);
    // Only the software-reset and sleep-out commands need the long settle time.
    has_delay    = (idx_q <= 5'd1);

    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    pix_lo_byte_d = pix_lo_byte_q;
    pix_lo_d      = pix_lo_q;
    nreset_d      = nreset_q;
    busy_d        = busy_q;
    dc_d          = dc_q;
    dout_d        = dout_q;
    we_d          = 1'b1;
    overrun_d     = busy_q & (bus.pix_clk | bus.reset_cursor);

    case (state_q)
      HW_HOLD: begin
        nreset_d = 1'b0;
        if (cnt_q == HOLD_LAST) begin
          nreset_d = 1'b1;
          cnt_d    = '0;
          state_d  = HW_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HW_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d          = '0;
          idx_d          = 5'd0;
          state_d        = SEQ;
          we_d           = 1'b0;
          {dc_d, dout_d} = first_entry;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Phase A has write_edge low; the phase-B cycle decides what follows.
      SEQ: begin
        if (!we_q) begin
          we_d = 1'b1;
        end else if (has_delay) begin
          cnt_d   = '0;
          state_d = DELAY;
        end else if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d          = idx_q + 5'd1;
          we_d           = 1'b0;
          {dc_d, dout_d} = next_entry;
        end
      end

      DELAY: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d          = '0;
          idx_d          = idx_q + 5'd1;
          state_d        = SEQ;
          we_d           = 1'b0;
          {dc_d, dout_d} = next_entry;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      IDLE: begin
        if (bus.reset_cursor) begin
          idx_d          = CURSOR_IDX;
          busy_d         = 1'b1;
          state_d        = SEQ;
          we_d           = 1'b0;
          {dc_d, dout_d} = cursor_entry;
          overrun_d      = bus.pix_clk;
        end else if (bus.pix_clk) begin
          pix_lo_byte_d = bus.pix_data[7:0];
          pix_lo_d      = 1'b0;
          busy_d        = 1'b1;
          state_d       = PIXEL;
          we_d          = 1'b0;
          dc_d          = 1'b1;
          dout_d        = bus.pix_data[15:8];
        end
      end

      PIXEL: begin
        if (!we_q) begin
          we_d = 1'b1;
        end else if (!pix_lo_q) begin
          pix_lo_d = 1'b1;
          we_d     = 1'b0;
          dc_d     = 1'b1;
          dout_d   = pix_lo_byte_q;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = HW_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= HW_HOLD;
      cnt_q         <= '0;
      idx_q         <= 5'd0;
      pix_lo_byte_q <= 8'h00;
      pix_lo_q      <= 1'b0;
      nreset_q      <= 1'b0;
      busy_q        <= 1'b1;
      overrun_q     <= 1'b0;
      we_q          <= 1'b1;
      dc_q          <= 1'b1;
      dout_q        <= 8'h00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pix_lo_byte_q <= pix_lo_byte_d;
      pix_lo_q      <= pix_lo_d;
      nreset_q      <= nreset_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      we_q          <= we_d;
      dc_q          <= dc_d;
      dout_q        <= dout_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
  assign bus.nreset     = nreset_q;
  assign bus.cmd_data   = dc_q;
  assign bus.write_edge = we_q;
  assign bus.dout       = dout_q;

endmodule

// File: tb/tb_lcd_pixel_writer.sv
// Directed bench for lcd_pixel_writer: a cycle schedule built from bus-level
// actions (reset, idle gaps, 2-cycle bytes) is compared with the DUT every cycle.
module tb_lcd_pixel_writer;

  localparam int HOLD = 4;
  localparam int WAIT = 8;
  localparam int NCYC = 512;
  localparam int END_CYC = 210;

  // {dc, byte} of the init sequence as listed for the panel.
  localparam logic [8:0] INIT_LOG [18] = '{
    9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h128, 9'h029,
    9'h02A, 9'h100, 9'h100, 9'h101, 9'h13F,
    9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02C
  };

  typedef struct packed {
    logic       nreset;
    logic       busy;
    logic       we;
    logic       dc;
    logic [7:0] dout;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  lcd_pixel_writer_if bus_if ();

  lcd_pixel_writer #(
    .RESET_HOLD (HOLD),
    .RESET_WAIT (WAIT),
    .MADCTL     (8'h28)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  exp_t exp_q   [NCYC];
  bit   exp_v   [NCYC];
  bit   exp_ovr [NCYC];
  logic h_busy  [NCYC];
  logic h_we    [NCYC];
  logic h_nrst  [NCYC];
  logic h_ovr   [NCYC];

  int         mp;
  logic       m_nreset;
  logic       m_busy;
  logic       m_dc;
  logic [7:0] m_dout;

  int total = 0;
  int bad   = 0;

  logic [8:0] byte_log [$];
  logic [8:0] want_log [$];

  logic [12:0] got_v;
  logic [12:0] want_v;

  // ---------------- behavioural schedule model ----------------
  function automatic void put(input logic we, input logic dc, input logic [7:0] b);
    exp_q[mp] = {m_nreset, m_busy, we, dc, b};
    exp_v[mp] = 1'b1;
    mp++;
  endfunction

  function automatic void m_reset(input int n);
    m_nreset = 1'b0;
    m_busy   = 1'b1;
    m_dc     = 1'b1;
    m_dout   = 8'h00;
    for (int i = 0; i < n; i++) put(1'b1, m_dc, m_dout);
  endfunction

  function automatic void m_idle_until(input int n);
    while (mp < n) put(1'b1, m_dc, m_dout);
  endfunction

  function automatic void m_idle(input int n);
    m_idle_until(mp + n);
  endfunction

  function automatic void m_byte(input logic dc, input logic [7:0] b);
    m_busy = 1'b1;
    put(1'b0, dc, b);
    put(1'b1, dc, b);
    m_dc   = dc;
    m_dout = b;
  endfunction

  function automatic void m_cursor();
    m_byte(1'b0, 8'h2A);
    m_byte(1'b1, 8'h00); m_byte(1'b1, 8'h00); m_byte(1'b1, 8'h01); m_byte(1'b1, 8'h3F);
    m_byte(1'b0, 8'h2B);
    m_byte(1'b1, 8'h00); m_byte(1'b1, 8'h00); m_byte(1'b1, 8'h00); m_byte(1'b1, 8'hEF);
    m_byte(1'b0, 8'h2C);
    m_busy = 1'b0;
  endfunction

  // The last reset-edge cycle already counts as the first nreset-low cycle.
  function automatic void m_init();
    m_idle(HOLD - 1);
    m_nreset = 1'b1;
    m_idle(WAIT);
    m_byte(1'b0, 8'h01);
    m_idle(WAIT);
    m_byte(1'b0, 8'h11);
    m_idle(WAIT);
    m_byte(1'b0, 8'h3A);
    m_byte(1'b1, 8'h55);
    m_byte(1'b0, 8'h36);
    m_byte(1'b1, 8'h28);
    m_byte(1'b0, 8'h29);
    m_cursor();
  endfunction

  function automatic void m_pixel(input logic [15:0] p);
    m_byte(1'b1, p[15:8]);
    m_byte(1'b1, p[7:0]);
    m_busy = 1'b0;
  endfunction

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk_i) begin
    if (cyc > 0 && cyc < NCYC) begin
      h_busy[cyc] = bus_if.busy;
      h_we[cyc]   = bus_if.write_edge;
      h_nrst[cyc] = bus_if.nreset;
      h_ovr[cyc]  = bus_if.overrun;
      if (bus_if.write_edge === 1'b0)
        byte_log.push_back({bus_if.cmd_data, bus_if.dout});
      if (exp_v[cyc]) begin
        got_v  = {bus_if.nreset, bus_if.busy, bus_if.overrun, bus_if.write_edge,
                  bus_if.cmd_data, bus_if.dout};
        want_v = {exp_q[cyc].nreset, exp_q[cyc].busy, exp_ovr[cyc], exp_q[cyc].we,
                  exp_q[cyc].dc, exp_q[cyc].dout};
        total++;
        if (got_v !== want_v) begin
          bad++;
          $display("[TB] FAIL cycle %0d outputs: got nreset=%b busy=%b ovr=%b we=%b dc=%b dout=%h, want nreset=%b busy=%b ovr=%b we=%b dc=%b dout=%h",
                   cyc, got_v[12], got_v[11], got_v[10], got_v[9], got_v[8], got_v[7:0],
                   want_v[12], want_v[11], want_v[10], want_v[9], want_v[8], want_v[7:0]);
        end
      end
    end
  end

  // ---------------- stimulus / literal checks ----------------
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic apply_stimulus(input int at, input logic pix, input logic cur,
                                input logic [15:0] data);
    wait_cyc(at);
    bus_if.pix_clk      = pix;
    bus_if.reset_cursor = cur;
    bus_if.pix_data     = data;
    wait_cyc(at + 1);
    bus_if.pix_clk      = 1'b0;
    bus_if.reset_cursor = 1'b0;
    bus_if.pix_data     = 16'h0000;
  endtask

  task automatic check_output(input string name, input logic [15:0] got,
                              input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus_if.pix_data     = 16'h0000;
    bus_if.pix_clk      = 1'b0;
    bus_if.reset_cursor = 1'b0;
    rst_i               = 1'b1;

    // Whole-run schedule; cycle k is what the outputs show after clock edge k.
    mp = 1;
    m_reset(3);
    m_init();
    exp_ovr[11] = 1'b1;
    m_idle_until(71);  m_pixel(16'hF81F);
    m_idle_until(81);  m_pixel(16'h1234);
    exp_ovr[83] = 1'b1;
    m_idle_until(86);  m_pixel(16'h5A3C);
    m_idle_until(96);  m_cursor();
    exp_ovr[96] = 1'b1;
    m_idle_until(121); m_pixel(16'h07E0);
    m_idle_until(131); m_byte(1'b1, 8'h13);
    put(1'b0, 1'b1, 8'h57);
    m_reset(2);
    m_init();
    m_idle_until(END_CYC);

    $display("[TB] power-up with pixel request during HW_WAIT");
    wait_cyc(3);
    rst_i = 1'b0;
    apply_stimulus(10, 1'b1, 1'b0, 16'hBEEF);

    $display("[TB] single pixel, back-to-back pixels, cursor collision");
    apply_stimulus(70, 1'b1, 1'b0, 16'hF81F);
    apply_stimulus(80, 1'b1, 1'b0, 16'h1234);
    apply_stimulus(82, 1'b1, 1'b0, 16'hABCD);
    apply_stimulus(85, 1'b1, 1'b0, 16'h5A3C);
    apply_stimulus(95, 1'b1, 1'b1, 16'hCAFE);
    apply_stimulus(120, 1'b1, 1'b0, 16'h07E0);

    $display("[TB] reset during second pixel byte");
    apply_stimulus(130, 1'b1, 1'b0, 16'h1357);
    wait_cyc(133);
    rst_i = 1'b1;
    wait_cyc(135);
    rst_i = 1'b0;

    wait_cyc(END_CYC - 1);
    @(negedge clk_i);
    #1;

    check_output("nreset_low_c6",   {15'd0, h_nrst[6]},  16'd0);
    check_output("nreset_high_c7",  {15'd0, h_nrst[7]},  16'd1);
    check_output("busy_last_c66",   {15'd0, h_busy[66]}, 16'd1);
    check_output("busy_fall_c67",   {15'd0, h_busy[67]}, 16'd0);
    check_output("pix_we_low_c71",  {15'd0, h_we[71]},   16'd0);
    check_output("pix_we_high_c72", {15'd0, h_we[72]},   16'd1);
    check_output("pix_we_low_c73",  {15'd0, h_we[73]},   16'd0);
    check_output("pix_busy_c74",    {15'd0, h_busy[74]}, 16'd1);
    check_output("pix_idle_c75",    {15'd0, h_busy[75]}, 16'd0);
    check_output("overrun_c83",     {15'd0, h_ovr[83]},  16'd1);
    check_output("overrun_c84",     {15'd0, h_ovr[84]},  16'd0);
    check_output("rst_we_c134",     {15'd0, h_we[134]},  16'd1);
    check_output("rst_nreset_c134", {15'd0, h_nrst[134]}, 16'd0);
    check_output("rst_busy_c134",   {15'd0, h_busy[134]}, 16'd1);

    foreach (INIT_LOG[i]) want_log.push_back(INIT_LOG[i]);
    want_log.push_back(9'h1F8); want_log.push_back(9'h11F);
    want_log.push_back(9'h112); want_log.push_back(9'h134);
    want_log.push_back(9'h15A); want_log.push_back(9'h13C);
    for (int i = 7; i < 18; i++) want_log.push_back(INIT_LOG[i]);
    want_log.push_back(9'h107); want_log.push_back(9'h1E0);
    want_log.push_back(9'h113); want_log.push_back(9'h157);
    foreach (INIT_LOG[i]) want_log.push_back(INIT_LOG[i]);

    check_output("byte_log_len", 16'(byte_log.size()), 16'(want_log.size()));
    for (int i = 0; i < want_log.size() && i < byte_log.size(); i++)
      check_output($sformatf("byte_log[%0d]", i), {7'd0, byte_log[i]}, {7'd0, want_log[i]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
